// File: rtl/seq_divider.sv
// seq_divider: RV32M-style sequential divider.
// Restoring radix-2 core, fixed latency, signed fix-up at the end.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] res_q;
  logic             rsel_q;
  logic             negq_q;
  logic             negr_q;

  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             ovf;
  logic             special;
  logic [WIDTH-1:0] spec_res;
  logic             accept;
  logic             last;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             fits;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] fixed;

  assign sgn      = ~op[0];
  assign a_neg    = sgn & dividend[WIDTH-1];
  assign b_neg    = sgn & divisor[WIDTH-1];
  assign a_mag    = a_neg ? -dividend : dividend;
  assign b_mag    = b_neg ? -divisor : divisor;
  assign div_zero = (divisor == '0);
  assign ovf      = sgn & (dividend == MINV)
                  & (divisor == '1);
  assign special  = div_zero | ovf;
  assign accept   = (state_q == IDLE) & start & ~abort;
  assign last     = (cnt_q == CW'(WIDTH));

  // Shift in the next dividend bit and trial-subtract the divisor;
  // the extra top bit of the difference is the borrow.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {2'b00, dvs_q};
  assign fits    = ~diff[WIDTH+1];
  assign rem_d   = fits ? diff[WIDTH:0] : shifted[WIDTH:0];

  assign q_fix = negq_q ? -quo_q : quo_q;
  assign r_fix = negr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  assign fixed = rsel_q ? r_fix : q_fix;

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = res_q;

  // Result for divide-by-zero and signed overflow, no iteration needed.
  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      div_zero: spec_res = op[1] ? dividend : '1;
      ovf:      spec_res = op[1] ? '0 : dividend;
      default:  spec_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort wins over everything outside IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = special ? DONE : RUN;
      end
      RUN: begin
        if (abort)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch operands, iterate, then sign-fix into result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      res_q  <= '0;
      rsel_q <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (accept) begin
      rsel_q <= op[1];
      negq_q <= a_neg ^ b_neg;
      negr_q <= a_neg;
      dvs_q  <= b_mag;
      quo_q  <= a_mag;
      rem_q  <= '0;
      cnt_q  <= '0;
      if (special) res_q <= spec_res;
    end else if ((state_q == RUN) && !abort) begin
      if (last) begin
        res_q <= fixed;
      end else begin
        rem_q <= rem_d;
        quo_q <= {quo_q[WIDTH-2:0], fits};
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed table, corner sequences and
// randomized ops against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 32;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         abort = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int passed = 0;
  int total = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    logic [7:0]   lat;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (b == '0) return o[1] ? a : '1;
    if (!o[0] && a == MINV && b == '1) return o[1] ? '0 : a;
    case (o)
      2'd0:    return sa / sb;
      2'd1:    return a / b;
      2'd2:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    if (b == '0) return 0;
    if (!o[0] && a == MINV && b == '1) return 0;
    return W + 1;
  endfunction

  task automatic issue(input logic [1:0] o,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(negedge clk);
    op = o;
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name,
                           input logic [W-1:0] exp,
                           input int lat);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, " latency"}, n, lat);
    chk({name, " result"}, result, exp);
    @(posedge clk);
    #1;
    chk({name, " pulse"}, {30'd0, busy, done}, '0);
    chk({name, " hold"}, result, exp);
  endtask

  task automatic run_op(input string name,
                        input logic [1:0] o,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] exp,
                        input int lat);
    issue(o, a, b);
    wait_done(name, exp, lat);
  endtask

  initial begin
    int n;
    int bc;
    int seen;
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    tbl[0]  = '{2'd1, 32'd100, 32'd7, 32'd14, 8'd33};
    tbl[1]  = '{2'd3, 32'd100, 32'd7, 32'd2, 8'd33};
    tbl[2]  = '{2'd0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 8'd33};
    tbl[3]  = '{2'd2, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 8'd33};
    tbl[4]  = '{2'd0, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 8'd33};
    tbl[5]  = '{2'd1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 8'd0};
    tbl[6]  = '{2'd3, 32'h1234, 32'd0, 32'h1234, 8'd0};
    tbl[7]  = '{2'd0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 8'd0};
    tbl[8]  = '{2'd2, 32'h1234, 32'd0, 32'h1234, 8'd0};
    tbl[9]  = '{2'd0, MINV, 32'hFFFF_FFFF, MINV, 8'd0};
    tbl[10] = '{2'd2, MINV, 32'hFFFF_FFFF, 32'd0, 8'd0};
    tbl[11] = '{2'd1, MINV, 32'hFFFF_FFFF, 32'd0, 8'd33};
    tbl[12] = '{2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 8'd33};
    tbl[13] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 8'd33};
    tbl[14] = '{2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 8'd33};
    tbl[15] = '{2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 8'd33};

    // reset state, before any clock edge
    #1;
    chk("rst busy", {31'd0, busy}, '0);
    chk("rst done", {31'd0, done}, '0);
    chk("rst result", result, '0);

    // start already high when reset releases
    #20;
    op = 2'd1;
    dividend = 32'h1000;
    divisor = 32'h10;
    start = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("first edge busy", {31'd0, busy}, 32'd1);
    wait_done("first edge", 32'h100, W + 1);

    // directed table
    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a,
             tbl[i].b, tbl[i].exp, int'(tbl[i].lat));
    end

    // busy profile and exact done timing, DIVU 100/7
    issue(2'd1, 32'd100, 32'd7);
    bc = 0;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      if (busy && !done) bc++;
    end
    chk("busy cycles", bc, W);
    @(posedge clk);
    #1;
    chk("done early", {31'd0, done}, '0);
    @(posedge clk);
    #1;
    chk("done at 33", {31'd0, done}, 32'd1);
    chk("divu 100/7", result, 32'd14);
    @(posedge clk);
    #1;
    chk("divu pulse", {31'd0, done}, '0);

    // start pulsed mid-run is ignored
    issue(2'd1, 32'd100, 32'd7);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == 5);
      if (n == 5) begin
        dividend = 32'd50;
        divisor = 32'd5;
      end
    end
    start = 1'b0;
    chk("restart latency", n, W + 1);
    chk("restart result", result, 32'd14);
    @(posedge clk);
    #1;

    // abort at iteration 10
    issue(2'd3, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort busy", {31'd0, busy}, '0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("abort no done", seen, 0);
    chk("abort result", result, 32'd14);
    run_op("after abort", 2'd1, 32'd9, 32'd3, 32'd3, W + 1);

    // abort and start together in IDLE
    @(negedge clk);
    op = 2'd1;
    dividend = 32'd9;
    divisor = 32'd3;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort+start busy", {30'd0, busy, done}, '0);

    // asynchronous reset mid-run
    issue(2'd3, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst outs", {31'd0, busy | done}, '0);
    chk("arst result", result, '0);
    #7;
    rst_n = 1'b1;
    seen = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("arst no done", seen, 0);
    run_op("after arst", 2'd0, 32'hFFFF_FF9C, 32'd7,
           32'hFFFF_FFF2, W + 1);

    // randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: begin
          rb = '1;
          if ($urandom_range(0, 1) == 1) ra = MINV;
        end
        2: rb = 32'($urandom_range(1, 20));
        3: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = MINV;
      run_op($sformatf("rnd%0d op%0d %h/%h", i, ro, ra, rb),
             ro, ra, rb, model(ro, ra, rb),
             model_lat(ro, ra, rb));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
